// File: rtl/ram_arb2_if.sv
// rtl/ram_arb2_if.sv - bus bundle between two masters, the arbiter and the RAM port
//
// Purpose: groups both master req/ack handshakes and the RAM-side signals.
// Modports:
//   slave  - arbiter view: takes master requests and RAM read data,
//            drives acks, master read data, RAM address/data/write enable, busy.
//   master - environment view (masters + RAM): the mirror image.
interface ram_arb2_if #(
  parameter int CAddrLen = 8,
  parameter int CDataLen = 8
);
  logic                AReq0;
  logic                AWr0;
  logic [CAddrLen-1:0] AAddr0;
  logic [CDataLen-1:0] AMosi0;
  logic                AAck0;
  logic [CDataLen-1:0] AMiso0;

  logic                AReq1;
  logic                AWr1;
  logic [CAddrLen-1:0] AAddr1;
  logic [CDataLen-1:0] AMosi1;
  logic                AAck1;
  logic [CDataLen-1:0] AMiso1;

  logic [CAddrLen-1:0] ARamAddrWr;
  logic [CAddrLen-1:0] ARamAddrRd;
  logic [CDataLen-1:0] ARamMosi;
  logic                ARamWrEn;
  logic [CDataLen-1:0] ARamMiso;
  logic                ABusy;

  modport slave (
    input  AReq0, AWr0, AAddr0, AMosi0,
    output AAck0, AMiso0,
    input  AReq1, AWr1, AAddr1, AMosi1,
    output AAck1, AMiso1,
    output ARamAddrWr, ARamAddrRd, ARamMosi, ARamWrEn,
    input  ARamMiso,
    output ABusy
  );

  modport master (
    output AReq0, AWr0, AAddr0, AMosi0,
    input  AAck0, AMiso0,
    output AReq1, AWr1, AAddr1, AMosi1,
    input  AAck1, AMiso1,
    input  ARamAddrWr, ARamAddrRd, ARamMosi, ARamWrEn,
    output ARamMiso,
    input  ABusy
  );
endinterface

// File: rtl/ram_arb2.sv
// rtl/ram_arb2.sv - two-master round-robin arbiter and sequencer for the peripheral RAM port
//
// Purpose: grants one of two req/ack masters access to a single RAM, drives the
// RAM address/data/write enable, waits CRdLat enabled cycles for read data and
// returns it to the granted master with a one-cycle ack.
// Ports:
//   AClkH    - clock, rising edge
//   AResetHN - asynchronous active-low reset
//   AClkHEn  - clock enable; all state holds while 0
//   bus      - ram_arb2_if.slave: master 0/1 handshakes, RAM port, ABusy
module ram_arb2 #(
  parameter int CAddrLen = 8,
  parameter int CDataLen = 8,
  parameter int CRdLat   = 1
) (
  input  logic       AClkH,
  input  logic       AResetHN,
  input  logic       AClkHEn,
  ram_arb2_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_ptr;     // 0: master 0 preferred on a tie
  logic                r_gnt;     // granted master of the current transaction
  logic                r_wr;
  logic [CAddrLen-1:0] r_addr;
  logic [CDataLen-1:0] r_mosi;
  logic [CDataLen-1:0] r_miso0;
  logic [CDataLen-1:0] r_miso1;
  logic [1:0]          r_cnt;
  logic                w_grant;
  logic                w_sel;

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
      r_gnt   <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_mosi  <= '0;
      r_miso0 <= '0;
      r_miso1 <= '0;
      r_cnt   <= 2'd0;
    end else if (AClkHEn) begin
      r_state <= w_next;
      if (w_grant) begin
        r_gnt  <= w_sel;
        r_wr   <= w_sel ? bus.AWr1   : bus.AWr0;
        r_addr <= w_sel ? bus.AAddr1 : bus.AAddr0;
        r_mosi <= w_sel ? bus.AMosi1 : bus.AMosi0;
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= 2'(CRdLat);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 2'd1;
      end
      // Sampling on the count of 1 puts the capture CRdLat edges after Issue.
      if (r_state == S_WAIT && r_cnt == 2'd1) begin
        if (r_gnt) begin
          r_miso1 <= bus.ARamMiso;
        end else begin
          r_miso0 <= bus.ARamMiso;
        end
      end
      if (r_state == S_ACK) begin
        r_ptr <= ~r_gnt;
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_sel   = r_gnt;
    case (r_state)
      S_IDLE: begin
        if (bus.AReq0 || bus.AReq1) begin
          w_grant = 1'b1;
          w_sel   = (bus.AReq0 && bus.AReq1) ? r_ptr : bus.AReq1;
          w_next  = S_ISSUE;
        end
      end
      S_ISSUE: w_next = r_wr ? S_ACK : S_WAIT;
      S_WAIT:  if (r_cnt == 2'd1) w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // RAM address/data come straight from the latch registers, so they hold
  // their last values between transactions. Write enable and ack decode the
  // state, so an asynchronous reset removes them immediately.
  always_comb begin
    bus.ARamAddrWr = r_addr;
    bus.ARamAddrRd = r_addr;
    bus.ARamMosi   = r_mosi;
    bus.ARamWrEn   = (r_state == S_ISSUE) && r_wr;
    bus.AAck0      = (r_state == S_ACK) && !r_gnt;
    bus.AAck1      = (r_state == S_ACK) && r_gnt;
    bus.AMiso0     = r_miso0;
    bus.AMiso1     = r_miso1;
    bus.ABusy      = (r_state != S_IDLE);
  end

endmodule

// File: tb/tb_ram_arb2.sv
// tb/tb_ram_arb2.sv - directed table-driven bench for ram_arb2 (CRdLat 1 and 3)
module tb_ram_arb2;

  logic clk;
  logic rst_n;
  logic en;

  ram_arb2_if #(.CAddrLen(8), .CDataLen(8)) bus1 ();
  ram_arb2_if #(.CAddrLen(8), .CDataLen(8)) bus3 ();

  ram_arb2 #(.CAddrLen(8), .CDataLen(8), .CRdLat(1)) u_dut1 (
    .AClkH(clk), .AResetHN(rst_n), .AClkHEn(en), .bus(bus1)
  );
  ram_arb2 #(.CAddrLen(8), .CDataLen(8), .CRdLat(3)) u_dut3 (
    .AClkH(clk), .AResetHN(rst_n), .AClkHEn(en), .bus(bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: read data = address ^ 0x4A, delivered after a pipeline of
  // enabled clocks. The second model's depth is selectable to show what a
  // wrong latency does.
  logic [7:0] r_p1;
  logic [7:0] r_p3 [0:3];
  int         model_lat = 3;

  always_ff @(posedge clk) begin
    if (en) begin
      r_p1    <= bus1.ARamAddrRd ^ 8'h4A;
      r_p3[0] <= bus3.ARamAddrRd ^ 8'h4A;
      r_p3[1] <= r_p3[0];
      r_p3[2] <= r_p3[1];
      r_p3[3] <= r_p3[2];
    end
  end
  assign bus1.ARamMiso = r_p1;
  assign bus3.ARamMiso = (model_lat == 4) ? r_p3[3] : r_p3[2];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
    else n_pass++;
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       pre_rst;
    logic       req0, wr0;
    logic [7:0] a0, d0;
    logic       req1, wr1;
    logic [7:0] a1, d1;
    logic       ack0, ack1, busy, wren;
    logic [7:0] raddr, rmosi;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic pre_rst,
    input logic req0, input logic wr0, input logic [7:0] a0, input logic [7:0] d0,
    input logic req1, input logic wr1, input logic [7:0] a1, input logic [7:0] d1,
    input logic ack0, input logic ack1, input logic busy, input logic wren,
    input logic [7:0] raddr, input logic [7:0] rmosi);
    vec_t v;
    v.pre_rst = pre_rst;
    v.req0 = req0; v.wr0 = wr0; v.a0 = a0; v.d0 = d0;
    v.req1 = req1; v.wr1 = wr1; v.a1 = a1; v.d1 = d1;
    v.ack0 = ack0; v.ack1 = ack1; v.busy = busy; v.wren = wren;
    v.raddr = raddr; v.rmosi = rmosi;
    return v;
  endfunction

  initial begin
    int n;
    bit wr_seen;
    logic both;

    // Single write from master 0: Issue, Ack, Idle, Idle.
    tbl.push_back(mk(0, 1,1,8'h3C,8'hA5, 0,0,8'h00,8'h00, 0,0,1,1, 8'h3C,8'hA5));
    tbl.push_back(mk(0, 1,1,8'h3C,8'hA5, 0,0,8'h00,8'h00, 1,0,1,0, 8'h3C,8'hA5));
    tbl.push_back(mk(0, 0,1,8'h3C,8'hA5, 0,0,8'h00,8'h00, 0,0,0,0, 8'h3C,8'hA5));
    tbl.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0, 8'h3C,8'hA5));
    // Both masters writing continuously from reset: grants 0,1,0,1,0,1.
    for (int k = 0; k < 6; k++) begin
      logic m;
      logic [7:0] ea, ed;
      m    = k[0];
      ea   = m ? 8'h02 : 8'h01;
      ed   = m ? 8'h22 : 8'h11;
      both = (k != 5);
      tbl.push_back(mk(k == 0, 1,1,8'h01,8'h11, 1,1,8'h02,8'h22, 0,0,1,1, ea,ed));
      tbl.push_back(mk(0, 1,1,8'h01,8'h11, 1,1,8'h02,8'h22, !m,m,1,0, ea,ed));
      tbl.push_back(mk(0, both,1,8'h01,8'h11, both,1,8'h02,8'h22, 0,0,0,0, ea,ed));
    end

    rst_n = 1'b0;
    en    = 1'b1;
    bus1.AReq0 = 0; bus1.AWr0 = 0; bus1.AAddr0 = 0; bus1.AMosi0 = 0;
    bus1.AReq1 = 0; bus1.AWr1 = 0; bus1.AAddr1 = 0; bus1.AMosi1 = 0;
    bus3.AReq0 = 0; bus3.AWr0 = 0; bus3.AAddr0 = 0; bus3.AMosi0 = 0;
    bus3.AReq1 = 0; bus3.AWr1 = 0; bus3.AAddr1 = 0; bus3.AMosi1 = 0;
    tick();
    tick();
    chk1("rst ack0", bus1.AAck0, 1'b0);
    chk1("rst ack1", bus1.AAck1, 1'b0);
    chk1("rst busy", bus1.ABusy, 1'b0);
    chk1("rst wren", bus1.ARamWrEn, 1'b0);
    chk8("rst ramaddr", bus1.ARamAddrWr, 8'h00);
    chk8("rst rammosi", bus1.ARamMosi, 8'h00);
    chk8("rst miso0", bus1.AMiso0, 8'h00);
    chk8("rst miso1", bus3.AMiso1, 8'h00);
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      if (tbl[i].pre_rst) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      bus1.AReq0 = tbl[i].req0; bus1.AWr0 = tbl[i].wr0;
      bus1.AAddr0 = tbl[i].a0;  bus1.AMosi0 = tbl[i].d0;
      bus1.AReq1 = tbl[i].req1; bus1.AWr1 = tbl[i].wr1;
      bus1.AAddr1 = tbl[i].a1;  bus1.AMosi1 = tbl[i].d1;
      tick();
      chk1($sformatf("row%0d ack0", i), bus1.AAck0, tbl[i].ack0);
      chk1($sformatf("row%0d ack1", i), bus1.AAck1, tbl[i].ack1);
      chk1($sformatf("row%0d busy", i), bus1.ABusy, tbl[i].busy);
      chk1($sformatf("row%0d wren", i), bus1.ARamWrEn, tbl[i].wren);
      chk8($sformatf("row%0d ramaddr", i), bus1.ARamAddrWr, tbl[i].raddr);
      chk8($sformatf("row%0d rammosi", i), bus1.ARamMosi, tbl[i].rmosi);
    end

    // Read, CRdLat = 1: master 1 at 0x10, ack on the 4th cycle.
    bus1.AReq1 = 1; bus1.AWr1 = 0; bus1.AAddr1 = 8'h10;
    n = 0; wr_seen = 0;
    while (n < 20 && !bus1.AAck1) begin
      tick();
      n++;
      if (bus1.ARamWrEn) wr_seen = 1;
    end
    chki("rd1 ack edges", n, 3);
    chk8("rd1 miso1", bus1.AMiso1, 8'h5A);
    chk1("rd1 ack0 quiet", bus1.AAck0, 1'b0);
    chk1("rd1 no write", wr_seen, 1'b0);
    chk8("rd1 ramaddrrd", bus1.ARamAddrRd, 8'h10);
    bus1.AReq1 = 0;
    tick();
    chk1("rd1 ack1 single", bus1.AAck1, 1'b0);
    chk1("rd1 idle", bus1.ABusy, 1'b0);
    chk8("rd1 miso1 held", bus1.AMiso1, 8'h5A);

    // Clock enable 1,0,1,0...: a 3-edge read stretches by 2 disabled cycles.
    bus1.AReq0 = 1; bus1.AWr0 = 0; bus1.AAddr0 = 8'h20;
    n = 0;
    while (n < 20 && !bus1.AAck0) begin
      en = (n % 2 == 0);
      tick();
      n++;
    end
    chki("ce ack cycles", n, 5);
    chk8("ce miso0", bus1.AMiso0, 8'h6A);
    en = 0;
    tick();
    chk1("ce ack held 1", bus1.AAck0, 1'b1);
    tick();
    chk1("ce ack held 2", bus1.AAck0, 1'b1);
    bus1.AReq0 = 0;
    en = 1;
    tick();
    chk1("ce ack dropped", bus1.AAck0, 1'b0);
    chk1("ce idle", bus1.ABusy, 1'b0);

    // Read, CRdLat = 3: master 0 at 0x33, ack on the 6th cycle.
    bus3.AReq0 = 1; bus3.AWr0 = 0; bus3.AAddr0 = 8'h33;
    n = 0; wr_seen = 0;
    while (n < 20 && !bus3.AAck0) begin
      tick();
      n++;
      if (bus3.ARamWrEn) wr_seen = 1;
    end
    chki("rd3 ack edges", n, 5);
    chk8("rd3 miso0", bus3.AMiso0, 8'h79);
    chk1("rd3 no write", wr_seen, 1'b0);
    bus3.AReq0 = 0;
    tick();

    // Too-slow RAM model: the capture sees the previous address's data.
    model_lat = 4;
    bus3.AReq0 = 1; bus3.AAddr0 = 8'h44;
    n = 0;
    while (n < 20 && !bus3.AAck0) begin
      tick();
      n++;
    end
    chki("slowram ack edges", n, 5);
    chk8("slowram stale data", bus3.AMiso0, 8'h79);
    bus3.AReq0 = 0;
    tick();
    model_lat = 3;

    // Reset with DUT3 in Wait (master 1, pointer favouring 1) and DUT1 in a write Issue.
    bus3.AReq1 = 1; bus3.AWr1 = 0; bus3.AAddr1 = 8'h55;
    tick();
    bus1.AReq0 = 1; bus1.AWr0 = 1; bus1.AAddr0 = 8'h99; bus1.AMosi0 = 8'h42;
    tick();
    chk1("prerst dut1 wren", bus1.ARamWrEn, 1'b1);
    chk1("prerst dut3 busy", bus3.ABusy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("rst async dut3 busy", bus3.ABusy, 1'b0);
    chk1("rst async dut1 busy", bus1.ABusy, 1'b0);
    chk1("rst async dut1 wren", bus1.ARamWrEn, 1'b0);
    chk1("rst async dut3 ack1", bus3.AAck1, 1'b0);
    bus1.AReq0 = 0;
    bus3.AReq0 = 1; bus3.AWr0 = 1; bus3.AAddr0 = 8'h66; bus3.AMosi0 = 8'h01;
    bus3.AReq1 = 1; bus3.AWr1 = 1; bus3.AAddr1 = 8'h77; bus3.AMosi1 = 8'h02;
    tick();
    tick();
    chk1("in rst no ack1", bus3.AAck1, 1'b0);
    rst_n = 1'b1;
    tick();
    chk8("post rst first addr", bus3.ARamAddrWr, 8'h66);
    chk1("post rst first wren", bus3.ARamWrEn, 1'b1);
    tick();
    chk1("post rst ack0", bus3.AAck0, 1'b1);
    chk1("post rst ack1 quiet", bus3.AAck1, 1'b0);
    bus3.AReq0 = 0;
    tick();
    chk1("post rst idle", bus3.ABusy, 1'b0);
    tick();
    chk8("post rst second addr", bus3.ARamAddrWr, 8'h77);
    chk8("post rst second mosi", bus3.ARamMosi, 8'h02);
    tick();
    chk1("post rst ack1", bus3.AAck1, 1'b1);
    chk1("post rst ack0 quiet", bus3.AAck0, 1'b0);
    bus3.AReq1 = 0;
    tick();
    chk1("end idle", bus3.ABusy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_arb2.md
Name: ram_arb2

Overview:
- Two-requester arbiter and sequencer for the 8-bit-address / 8-bit-data peripheral RAM port: AAddrWr, AAddrRd, AMosi, AMiso, AWrEn.
- Lets two masters share one RAM instance using a req/ack handshake and round-robin priority.
- Counts the RAM read latency and returns read data to the granted master.
- Sits between the two bus masters and the RAM instance, in the same clock and clock-enable domain as the RAM.

Parameters:
- CAddrLen, 8: address width on the master and RAM sides.
- CDataLen, 8: data width.
- CRdLat, 1: enabled-clock cycles from AAddrRd applied to valid AMiso. Legal range 1..3.

Ports:
- AClkH  input  1  system clock, rising edge.
- AResetHN  input  1  asynchronous, active-low reset.
- AClkHEn  input  1  clock enable. All state advances only when it is 1.
- AReq0  input  1  master 0 request. Held high until AAck0.
- AWr0  input  1  master 0: 1 = write, 0 = read.
- AAddr0  input  CAddrLen  master 0 address.
- AMosi0  input  CDataLen  master 0 write data.
- AAck0  output  1  master 0 completion pulse.
- AMiso0  output  CDataLen  master 0 read data. Valid while AAck0 = 1.
- AReq1, AWr1, AAddr1, AMosi1, AAck1, AMiso1: master 1, identical to master 0.
- ARamAddrWr  output  CAddrLen  to RAM AAddrWr.
- ARamAddrRd  output  CAddrLen  to RAM AAddrRd.
- ARamMosi  output  CDataLen  to RAM AMosi.
- ARamWrEn  output  1  to RAM AWrEn.
- ARamMiso  input  CDataLen  from RAM AMiso.
- ABusy  output  1  high when the FSM is not in Idle.

Behaviour:
- Single clock AClkH. Reset is asynchronous and active-low on AResetHN.
- Reset values:
  - FSM = Idle; round-robin pointer = master 0 preferred.
  - All outputs 0.
  - Latched request registers 0.
- Every register update requires AClkHEn = 1. With AClkHEn = 0 everything holds, including ack.
- FSM states: Idle, Issue, Wait, Ack.
- Idle:
  - If exactly one AReq is high, grant that master.
  - If both are high, grant the master the pointer prefers.
  - On grant, latch Wr, Addr and Mosi of the granted master and go to Issue.
- Issue:
  - ARamAddrWr = ARamAddrRd = latched Addr; ARamMosi = latched Mosi.
  - Write: ARamWrEn = 1 for exactly this one enabled cycle; next state Ack.
  - Read: ARamWrEn = 0; load latency counter with CRdLat; next state Wait.
- Wait:
  - RAM address is held; the counter decrements each enabled cycle.
  - When the counter reaches 1, capture ARamMiso into the granted master's AMiso register and go to Ack.
  - Net effect: data is sampled CRdLat enabled cycles after Issue.
- Ack:
  - AAck of the granted master = 1 for exactly one enabled cycle. The other master's AAck stays 0.
  - AMiso of the granted master holds the captured value. On a write it holds its previous value.
  - The pointer is set to prefer the non-granted master. Next state Idle.
- RAM outputs outside Issue/Wait: ARamAddrWr, ARamAddrRd and ARamMosi hold their last values; ARamWrEn = 0.
- Requests are sampled only in Idle.
  - A master must keep AReq high until its AAck.
  - A master must drop AReq in the cycle after AAck, or it is granted again.
  - A request dropped before ack is undefined and need not be checked.
- Throughput:
  - Write: 3 enabled cycles per transaction (Idle, Issue, Ack).
  - Read: 3 + CRdLat enabled cycles.
  - Idle is always revisited, so there is no back-to-back grant without an Idle cycle.
- Fairness: with both requests held continuously, grants strictly alternate 0,1,0,1...
- Reset mid-transaction: return to Idle immediately. No ack is issued, ARamWrEn drops to 0 asynchronously, and the pointer returns to master 0.
- Width rule: no arithmetic on addresses or data. The counter is 2 bits.

Test Plan:
- Reset, then a single write: AReq0 = 1, AWr0 = 1, AAddr0 = 0x3C, AMosi0 = 0xA5 → ARamWrEn high exactly one cycle with ARamAddrWr = 0x3C and ARamMosi = 0xA5; AAck0 pulses 2 cycles after grant; AAck1 stays 0.
- Read with CRdLat = 1 and a RAM model returning 0x5A for address 0x10: AReq1 read at 0x10 → AAck1 at cycle 4 after request, AMiso1 = 0x5A, ARamWrEn never high.
- Both masters request continuously for 6 transactions, both at reset → grant order 0,1,0,1,0,1; each ack is a single cycle; ABusy drops for exactly one Idle cycle between transactions.
- CRdLat = 3: read from master 0 → data sampled 3 enabled cycles after Issue; ack at cycle 6; a RAM model with the wrong latency yields a mismatch.
- AClkHEn toggled 1,0,1,0 during a read → the transaction stretches exactly by the number of disabled cycles, and the ack stays high until the next enabled edge.
- AResetHN low while in Wait → ABusy = 0 and ARamWrEn = 0 immediately; no AAck; after release, a pending AReq1 and AReq0 grant master 0 first.
